// File: rtl/pipe_hazard_ctrl.sv
// Stage-register enable/flush control for the 5-stage MIPS core: RAW stall, EX redirect, memory freeze and watchdog.
// Optional FORWARDING_EN: when defined, only load-use hazards stall; otherwise any ID/EX or EX/MEM writer match stalls.
`default_nettype none

module pipe_hazard_ctrl #(
  parameter int unsigned MAX_WAIT = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] ifid_rs,
  input  logic [4:0] ifid_rt,
  input  logic [4:0] idex_rd,
  input  logic       idex_regwrite,
  input  logic       idex_memread,
  input  logic [4:0] exmem_rd,
  input  logic       exmem_regwrite,
  input  logic       ex_redirect,
  input  logic       mem_wait,
  output logic       pc_en,
  output logic       ifid_en,
  output logic       idex_en,
  output logic       exmem_en,
  output logic       memwb_en,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       mem_fault
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FAULT = 2'd2
  } state_t;

  localparam logic [7:0]       MAX_WAIT_C = 8'(MAX_WAIT);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  state_t           state_q, state_d;
  logic [7:0]       wait_cnt_q, wait_cnt_d, wait_nxt;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             hit_idex, hit_exmem, raw_stall;

  function automatic logic src_hit(input logic [4:0] src, input logic [4:0] dst, input logic wr);
    return (src != 5'd0) && (src == dst) && wr;
  endfunction

  assign hit_idex  = src_hit(ifid_rs, idex_rd, idex_regwrite)  | src_hit(ifid_rt, idex_rd, idex_regwrite);
  assign hit_exmem = src_hit(ifid_rs, exmem_rd, exmem_regwrite) | src_hit(ifid_rt, exmem_rd, exmem_regwrite);

`ifdef FORWARDING_EN
  // EX/MEM results are forwarded, so only a load still in EX forces a bubble.
  logic unused_fwd;
  assign unused_fwd = hit_exmem;
  assign raw_stall  = idex_memread && hit_idex;
`else
  logic unused_fwd;
  assign unused_fwd = idex_memread;
  assign raw_stall  = hit_idex || hit_exmem;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 8'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    wait_nxt    = (state_q == ST_RUN) ? 8'd1 : wait_cnt_q + 8'd1;
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    mem_fault   = 1'b0;

    case (state_q)
      ST_RUN, ST_WAIT: begin
        if (mem_wait) begin
          wait_cnt_d = wait_nxt;
          state_d    = (wait_nxt >= MAX_WAIT_C) ? ST_FAULT : ST_WAIT;
        end else begin
          wait_cnt_d = 8'd0;
          state_d    = ST_RUN;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
          idex_en    = 1'b1;
          if (ex_redirect) begin
            // The dependent instruction is wrong-path, so the redirect wins over a stall.
            pc_en       = 1'b1;
            ifid_en     = 1'b1;
            ifid_flush  = 1'b1;
            idex_flush  = 1'b1;
            flush_cnt_d = flush_cnt_q + CNT_ONE;
          end else if (raw_stall) begin
            idex_flush  = 1'b1;
            stall_cnt_d = stall_cnt_q + CNT_ONE;
          end else begin
            pc_en   = 1'b1;
            ifid_en = 1'b1;
          end
        end
      end
      ST_FAULT: mem_fault = 1'b1;
      default:  state_d = ST_RUN;
    endcase

    // Outputs are held inactive for as long as reset is asserted, not just after the next edge.
    if (!reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      mem_fault  = 1'b0;
    end
  end

endmodule

`default_nettype wire
